fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of a fifo_sync instance among NREQ producers.
- A granted producer owns the port for a burst of up to BURST beats. It then releases, and priority rotates to the next producer.
- Sits directly in front of the FIFO write interface and drives wr_en/wdata.
- Consumes the FIFO full flag, so that no write is ever issued into a full FIFO.

---
 rtl/fifo_arb_pkg.sv | 29 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int MAX_NREQ  = 8;
  localparam int MAX_IDX_W = 3;

  // ceil(log2(n)), never less than 1 so a 1-entry space still has a usable width.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [MAX_NREQ-1:0] onehot(input int idx);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    v[idx[MAX_IDX_W-1:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W:0] L_N = (IDX_W + 1)'(NREQ);

  logic [NREQ-1:0]  w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
  assign w_rot = NREQ'({req_i, req_i} >> rr_ptr_i);

  always_comb begin
    found_o = 1'b0;
    w_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found_o = 1'b1;
        w_off   = IDX_W'(i);
      end
    end
  end

  assign w_sum = {1'b0, rr_ptr_i} + {1'b0, w_off};
  assign idx_o = (w_sum >= L_N) ? IDX_W'(w_sum - L_N) : w_sum[IDX_W-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  parameter int IDX_W = clog2_min1(NREQ),
  parameter int CNT_W = clog2_min1(BURST)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] wdata_i,
  input  logic                  full_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       ack_o,
  output logic                  fifo_wr_en_o,
  output logic [WIDTH-1:0]      fifo_wdata_o,
  output logic [IDX_W-1:0]      owner_o,
  output logic                  busy_o
);

  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(BURST - 1);
  localparam logic [IDX_W-1:0] L_TOP  = IDX_W'(NREQ - 1);

  arb_state_e       r_state, w_state_nx;
  logic [IDX_W-1:0] r_owner, w_owner_nx;
  logic [IDX_W-1:0] r_rr, w_rr_nx;
  logic [NREQ-1:0]  r_gnt, w_gnt_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [IDX_W-1:0] w_pick_idx;
  logic [NREQ-1:0]  w_own_oh;
  logic             w_found, w_busy, w_own_req, w_beat, w_release;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i    (req_i),
    .rr_ptr_i (r_rr),
    .found_o  (w_found),
    .idx_o    (w_pick_idx)
  );

  assign w_busy    = (r_state == ST_GRANT);
  assign w_own_req = req_i[r_owner];
  // rst_i gating keeps the write strobe dead for the whole reset window.
  assign w_beat    = w_busy & w_own_req & ~full_i & rst_i;
  assign w_own_oh  = NREQ'(onehot(int'(r_owner)));

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_gnt_nx   = r_gnt;
    w_cnt_nx   = r_cnt;
    w_rr_nx    = r_rr;
    w_release  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nx = ST_GRANT;
          w_owner_nx = w_pick_idx;
          w_gnt_nx   = NREQ'(onehot(int'(w_pick_idx)));
          w_cnt_nx   = '0;
        end
      end
      ST_GRANT: begin
        if (!w_own_req) begin
          w_release = 1'b1;
        end else if (w_beat) begin
          if (r_cnt == L_LAST) w_release = 1'b1;
          else                 w_cnt_nx  = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_release) begin
      w_state_nx = ST_IDLE;
      w_gnt_nx   = '0;
      w_cnt_nx   = '0;
      w_rr_nx    = (r_owner == L_TOP) ? '0 : r_owner + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_gnt   <= w_gnt_nx;
      r_cnt   <= w_cnt_nx;
      r_rr    <= w_rr_nx;
    end
  end

  assign gnt_o        = r_gnt;
  assign ack_o        = w_beat ? w_own_oh : '0;
  assign fifo_wr_en_o = w_beat;
  assign fifo_wdata_o = w_busy ? wdata_i[int'(r_owner)*WIDTH +: WIDTH] : '0;
  assign owner_o      = r_owner;
  assign busy_o       = w_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: BURST=4 main instance plus a BURST=2 instance for rotation order.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i, req2_i;
  logic [31:0] wdata_i, wdata2_i;
  logic        full_i;

  logic [3:0]  gnt_o, ack_o, gnt2, ack2;
  logic        fifo_wr_en_o, wr_en2, busy_o, busy2;
  logic [7:0]  fifo_wdata_o, wdata2_o;
  logic [1:0]  owner_o, owner2;

  int          n_total = 0;
  int          n_pass  = 0;
  int          avail[NREQ];
  logic [7:0]  nxt[NREQ];
  logic [3:0]  drop_mask = 4'b0000;
  logic [15:0] exp_q[$];
  logic [3:0]  exp_gnt2_q[$];
  logic [3:0]  exp_gnt2_cur = 4'b0000;
  int          rr2_own = 0;
  bit          rr2_on = 1'b0;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .wdata_i(wdata_i), .full_i(full_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .fifo_wr_en_o(fifo_wr_en_o), .fifo_wdata_o(fifo_wdata_o),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req2_i), .wdata_i(wdata2_i), .full_i(full_i),
    .gnt_o(gnt2), .ack_o(ack2), .fifo_wr_en_o(wr_en2), .fifo_wdata_o(wdata2_o),
    .owner_o(owner2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] oh4(input int k);
    logic [3:0] v;
    v = 4'b0001 << k;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      req_i[k] = (avail[k] > 0) && !drop_mask[k];
      wdata_i[k*8 +: 8] = nxt[k];
    end
  endtask

  // Scoreboard side: every FIFO write must match the head of exp_q.
  task automatic monitor();
    logic [15:0] e;
    if (fifo_wr_en_o) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_owner_data", 32'({8'(owner_o), fifo_wdata_o}), 32'(e));
        chk("ack_owner", 32'(ack_o), 32'(oh4(int'(e[15:8]))));
      end
    end else begin
      chk("ack_idle", 32'(ack_o), 32'd0);
    end
    if (full_i) chk("no_wr_when_full", 32'(fifo_wr_en_o), 32'd0);
    if (rr2_on) begin
      chk("rr2_wr_en", 32'(wr_en2), 32'(exp_gnt2_cur != 4'b0000));
      chk("rr2_ack", 32'(ack2), 32'(exp_gnt2_cur));
      if (exp_gnt2_cur != 4'b0000) chk("rr2_data", 32'(wdata2_o), 32'(wdata2_i[rr2_own*8 +: 8]));
    end
  endtask

  task automatic tick();
    logic [3:0] a;
    @(negedge clk);
    monitor();
    a = ack_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (a[k]) begin
        avail[k] = avail[k] - 1;
        nxt[k]   = nxt[k] + 8'd1;
      end
    end
    drive();
    if (rr2_on) begin
      if (exp_gnt2_q.size() != 0) exp_gnt2_cur = exp_gnt2_q.pop_front();
      chk("rr2_gnt", 32'(gnt2), 32'(exp_gnt2_cur));
      for (int k = 0; k < NREQ; k++) if (exp_gnt2_cur[k]) rr2_own = k;
    end
  endtask

  task automatic drain(input string tag, input int budget, input bit rand_full);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy_o) && c < budget) begin
      if (rand_full) full_i = ($urandom_range(0, 3) == 0);
      tick();
      c++;
    end
    full_i = 1'b0;
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic push(input int k, input logic [7:0] d);
    exp_q.push_back({8'(k), d});
  endtask

  initial begin
    int          rem[NREQ];
    logic [7:0]  d[NREQ];
    int          rr, k, n, tot;

    rst_i = 1'b0; full_i = 1'b0; req2_i = 4'b0000; wdata2_i = 32'h44332211;
    for (int i = 0; i < NREQ; i++) begin avail[i] = 0; nxt[i] = 8'h00; end
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata_o), 32'd0);
    rst_i = 1'b1;

    // Single producer: 4-beat burst, one bubble, re-grant for the tail.
    avail[0] = 6; nxt[0] = 8'hA0;
    for (int j = 0; j < 6; j++) push(0, 8'(8'hA0 + j));
    drive();
    tick();
    chk("single_gnt", 32'(gnt_o), 32'b0001);
    chk("single_busy", 32'(busy_o), 32'd1);
    repeat (4) tick();
    chk("single_release_gnt", 32'(gnt_o), 32'd0);
    chk("single_release_busy", 32'(busy_o), 32'd0);
    tick();
    chk("single_regrant", 32'(gnt_o), 32'b0001);
    repeat (2) tick();
    chk("single_tail_busy", 32'(busy_o), 32'd1);
    tick();
    chk("single_drop_release", 32'(busy_o), 32'd0);
    chk("single_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while producer 2 is mid-burst.
    avail[2] = 10; nxt[2] = 8'hC0;
    push(2, 8'hC0);
    drive();
    tick();
    chk("rst_mid_owner", 32'(owner_o), 32'd2);
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt_o), 32'd0);
    chk("rst_async_wr_en", 32'(fifo_wr_en_o), 32'd0);
    chk("rst_async_busy", 32'(busy_o), 32'd0);
    chk("rst_async_ack", 32'(ack_o), 32'd0);
    chk("rst_async_wdata", 32'(fifo_wdata_o), 32'd0);
    avail[2] = 0;
    repeat (2) tick();
    rst_i = 1'b1;
    avail[0] = 1; nxt[0] = 8'hD0; avail[3] = 1; nxt[3] = 8'hE0;
    push(0, 8'hD0); push(3, 8'hE0);
    drive();
    tick();
    chk("rst_rr_ptr_zero", 32'(owner_o), 32'd0);
    drain("rst", 30, 1'b0);

    // Rotation: BURST=2 instance with all requests held high; main instance drains 4 each.
    for (int g = 0; g < 5; g++) begin
      exp_gnt2_q.push_back(oh4(g % 4));
      exp_gnt2_q.push_back(oh4(g % 4));
      exp_gnt2_q.push_back(4'b0000);
    end
    req2_i = 4'b1111; rr2_on = 1'b1; exp_gnt2_cur = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin
      avail[i] = 4; nxt[i] = 8'(8'h10 * (i + 1));
      for (int j = 0; j < 4; j++) push(i, 8'(nxt[i] + j));
    end
    drive();
    repeat (15) tick();
    rr2_on = 1'b0; req2_i = 4'b0000;
    drain("rr", 60, 1'b0);

    // Full stall on owner 1 after its first beat.
    avail[1] = 4; nxt[1] = 8'hB0;
    for (int j = 0; j < 4; j++) push(1, 8'(8'hB0 + j));
    drive();
    tick();
    chk("stall_gnt_start", 32'(gnt_o), 32'b0010);
    tick();
    full_i = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_gnt_held", 32'(gnt_o), 32'b0010);
      chk("stall_no_wr", 32'(fifo_wr_en_o), 32'd0);
      chk("stall_no_ack", 32'(ack_o), 32'd0);
    end
    full_i = 1'b0;
    drain("stall", 20, 1'b0);
    chk("stall_gnt_released", 32'(gnt_o), 32'd0);

    // A grant is still issued while the FIFO is full.
    full_i = 1'b1;
    avail[2] = 1; nxt[2] = 8'h77;
    push(2, 8'h77);
    drive();
    tick();
    chk("full_grant", 32'(gnt_o), 32'b0100);
    tick();
    chk("full_grant_no_wr", 32'(fifo_wr_en_o), 32'd0);
    full_i = 1'b0;
    drain("full_grant", 20, 1'b0);

    // Owner 3 drops after one beat; pointer wraps to 0.
    avail[3] = 5; nxt[3] = 8'h50;
    push(3, 8'h50);
    drive();
    tick();
    chk("drop_owner", 32'(owner_o), 32'd3);
    tick();
    drop_mask = 4'b1000;
    drive();
    #1;
    chk("drop_no_wr", 32'(fifo_wr_en_o), 32'd0);
    tick();
    chk("drop_release", 32'(busy_o), 32'd0);
    drop_mask = 4'b0000;
    avail[0] = 1; nxt[0] = 8'h60;
    push(0, 8'h60);
    for (int j = 1; j < 5; j++) push(3, 8'(8'h50 + j));
    drive();
    tick();
    chk("drop_wrap_owner", 32'(owner_o), 32'd0);
    chk("drop_wrap_gnt", 32'(gnt_o), 32'b0001);
    drain("drop", 40, 1'b0);

    // Data mux with random per-producer data, lengths and full_i stalls.
    for (int i = 0; i < NREQ; i++) begin
      avail[i] = $urandom_range(1, 6);
      nxt[i]   = 8'($urandom_range(0, 255));
      rem[i]   = avail[i];
      d[i]     = nxt[i];
    end
    rr = 0;
    for (int g = 0; g < 64; g++) begin
      tot = 0;
      for (int i = 0; i < NREQ; i++) tot += rem[i];
      if (tot == 0) break;
      k = rr;
      while (rem[k] == 0) k = (k + 1) % NREQ;
      n = (rem[k] < BURST) ? rem[k] : BURST;
      for (int j = 0; j < n; j++) begin
        push(k, d[k]);
        d[k] = d[k] + 8'd1;
      end
      rem[k] -= n;
      rr = (k + 1) % NREQ;
    end
    drive();
    drain("mux", 300, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
